// File: rtl/alu_pipelined.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_pipelined
//  Description : Two-stage pipelined ALU with valid/ready handshake on both
//                sides. Stage 1 captures the operands and opcode. Stage 2
//                captures the result and the status flags. The outputs are
//                driven straight from the stage-2 registers. Up to two
//                items are buffered while the consumer stalls.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    rst        in   synchronous active-high reset
//    in_valid   in   a/b/op carry an item this cycle
//    in_ready   out  block accepts an item this cycle
//    a          in   operand A [WIDTH]
//    b          in   operand B [WIDTH]; the low SHW bits are the shift amount
//    op         in   0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SHL 6 SHR 7 SLT(signed)
//    out_valid  out  out/flags carry a result
//    out_ready  in   consumer accepts the result
//    out        out  result [WIDTH]
//    flags      out  {overflow, negative, carry, zero}
// ============================================================================
module alu_pipelined #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_or  = 3'd3;
    localparam logic [2:0] c_op_xor = 3'd4;
    localparam logic [2:0] c_op_shl = 3'd5;
    localparam logic [2:0] c_op_shr = 3'd6;
    localparam logic [2:0] c_op_slt = 3'd7;

    localparam int         c_msb   = WIDTH - 1;
    localparam logic [WIDTH:0] c_width = (WIDTH+1)'(WIDTH);

    // Stage 1: captured operands
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;

    // Stage 2: captured result
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_res;
    logic [3:0]       r_flags;

    logic             w_adv1;
    logic             w_adv2;

    // A stage may load when it is empty or when its content moves on this
    // cycle; readiness never looks at in_valid.
    assign w_adv2    = ~r_s2_valid | out_ready;
    assign w_adv1    = ~r_s1_valid | w_adv2;
    assign in_ready  = w_adv1;

    assign out_valid = r_s2_valid;
    assign out       = r_res;
    assign flags     = r_flags;

    // ------------------------------------------------------------------
    // Execute (between the stages)
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [SHW-1:0]   w_shamt;
    logic             w_big;
    logic             w_lt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic [3:0]       w_flags;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    // Bit WIDTH of the extended difference is the borrow (set when a < b).
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
    assign w_shamt = r_b[SHW-1:0];
    // Any shift amount of WIDTH or more clears the result and the carry.
    assign w_big   = {1'b0, r_b} >= c_width;
    // One guard bit on the exiting side catches the last bit shifted out.
    assign w_shl   = {1'b0, r_a} << w_shamt;
    assign w_shr   = {r_a, 1'b0} >> w_shamt;
    assign w_lt    = $signed(r_a) < $signed(r_b);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_op)
            c_op_add: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (r_a[c_msb] == r_b[c_msb]) & (w_sum[c_msb] != r_a[c_msb]);
            end
            c_op_sub: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (r_a[c_msb] != r_b[c_msb]) & (w_diff[c_msb] != r_a[c_msb]);
            end
            c_op_and: w_res = r_a & r_b;
            c_op_or:  w_res = r_a | r_b;
            c_op_xor: w_res = r_a ^ r_b;
            c_op_shl: begin
                if (!w_big) begin
                    w_res   = w_shl[WIDTH-1:0];
                    w_carry = w_shl[WIDTH];
                end
            end
            c_op_shr: begin
                if (!w_big) begin
                    w_res   = w_shr[WIDTH:1];
                    w_carry = w_shr[0];
                end
            end
            c_op_slt: w_res = {{(WIDTH-1){1'b0}}, w_lt};
            default:  w_res = '0;
        endcase
    end

    assign w_flags = {w_ovf, w_res[c_msb], w_carry, (w_res == '0)};

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_flags    <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_a  <= a;
                    r_b  <= b;
                    r_op <= op;
                end
            end
            // An empty stage 1 advancing just clears s2_valid; the data
            // registers keep stale values that nobody samples.
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_res   <= w_res;
                    r_flags <= w_flags;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipelined.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipelined
//  Description : Self-checking bench for alu_pipelined (WIDTH=8 and WIDTH=16
//                instances). Directed steps plus a randomized phase scored
//                against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_pipelined;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [3:0] flags;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [2:0]  op16;
    logic        out_valid16;
    logic        out_ready16;
    logic [15:0] out16;
    logic [3:0]  flags16;

    int n_vec = 0;
    int n_bad = 0;

    logic [11:0] exp_q[$];
    logic [11:0] sb_e;
    logic [19:0] sb_m;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_out;
    logic [3:0]  prev_flags;

    int          bp_ir [6] = '{1, 1, 0, 0, 0, 0};
    int          got_q[$];
    int          nxt;

    always #5 clk = ~clk;

    alu_pipelined #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    alu_pipelined #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .op        (op16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out       (out16),
        .flags     (flags16)
    );

    // Reference model: returns {overflow, negative, carry, zero, out[15:0]}.
    function automatic logic [19:0] ref_alu(input int w, input longint unsigned x,
                                            input longint unsigned y, input int o);
        longint unsigned m = (64'd1 << w) - 64'd1;
        longint unsigned half = 64'd1 << (w - 1);
        longint unsigned r = 0;
        longint sx, sy;
        logic c = 1'b0;
        logic v = 1'b0;
        logic [19:0] res;
        case (o)
            0: begin
                r = (x + y) & m;
                c = (x + y) > m;
                v = ((x >= half) == (y >= half)) && ((r >= half) != (x >= half));
            end
            1: begin
                r = (x - y) & m;
                c = x < y;
                v = ((x >= half) != (y >= half)) && ((r >= half) != (x >= half));
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: if (y < longint'(w)) begin
                   r = (x << y) & m;
                   c = (y != 0) && (((x >> (longint'(w) - y)) & 64'd1) != 0);
               end
            6: if (y < longint'(w)) begin
                   r = x >> y;
                   c = (y != 0) && (((x >> (y - 1)) & 64'd1) != 0);
               end
            default: begin
                sx = (x >= half) ? longint'(x) - longint'(m) - 1 : longint'(x);
                sy = (y >= half) ? longint'(y) - longint'(m) - 1 : longint'(y);
                r  = (sx < sy) ? 64'd1 : 64'd0;
            end
        endcase
        res[15:0] = r[15:0];
        res[19]   = v;
        res[18]   = r >= half;
        res[17]   = c;
        res[16]   = r == 0;
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
    endtask

    task automatic single(input string tag, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] eo, input logic [3:0] ef);
        put(o, x, y);
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_out"}, 32'(out), 32'(eo));
        chk({tag, "_flg"}, 32'(flags), 32'(ef));
        tick();
    endtask

    task automatic single16(input string tag, input logic [2:0] o, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] eo, input logic [3:0] ef);
        in_valid16 = 1'b1;
        op16 = o;
        a16  = x;
        b16  = y;
        tick();
        in_valid16 = 1'b0;
        tick();
        chk({tag, "_vld"}, 32'(out_valid16), 32'd1);
        chk({tag, "_out"}, 32'(out16), 32'(eo));
        chk({tag, "_flg"}, 32'(flags16), 32'(ef));
        tick();
    endtask

    // Scoreboard and stall-stability monitor; sampled mid-cycle so that the
    // handshake seen here is the one taken at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", 32'({out_valid, flags, out}), 32'({1'b1, prev_flags, prev_out}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb", 32'({flags, out}), 32'(sb_e));
                end
            end
            if (in_valid && in_ready) begin
                sb_m = ref_alu(8, 64'(a), 64'(b), int'(op));
                exp_q.push_back({sb_m[19:16], sb_m[7:0]});
            end
            prev_stall = out_valid & ~out_ready;
            prev_out   = out;
            prev_flags = flags;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; out_ready16 = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_flg", 32'(flags), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_vld16", 32'(out_valid16), 32'd0);

        // Back-to-back stream, two-cycle latency
        put(3'd0, 8'd42, 8'd99);
        tick();
        chk("lat_1cyc", 32'(out_valid), 32'd0);
        put(3'd1, 8'd99, 8'd42);
        tick();
        chk("b2b_add_vld", 32'(out_valid), 32'd1);
        chk("b2b_add", 32'({flags, out}), 32'({4'b1100, 8'd141}));
        put(3'd2, 8'd1, 8'd0);
        tick();
        chk("b2b_sub", 32'({out_valid, flags, out}), 32'({1'b1, 4'b0000, 8'd57}));
        put(3'd3, 8'd1, 8'd0);
        tick();
        chk("b2b_and", 32'({out_valid, flags, out}), 32'({1'b1, 4'b0001, 8'd0}));
        in_valid = 1'b0;
        tick();
        chk("b2b_or", 32'({out_valid, flags, out}), 32'({1'b1, 4'b0000, 8'd1}));
        tick();
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // Carry / borrow, shifts, signed compare
        single("add_carry", 3'd0, 8'd200, 8'd100, 8'd44,  4'b0010);
        single("sub_borrow", 3'd1, 8'd5,  8'd7,   8'd254, 4'b0110);
        single("sub_zero",  3'd1, 8'd7,   8'd7,   8'd0,   4'b0001);
        single("shl",       3'd5, 8'h81,  8'd1,   8'h02,  4'b0010);
        single("shr",       3'd6, 8'h81,  8'd1,   8'h40,  4'b0010);
        single("shl_big",   3'd5, 8'hFF,  8'd8,   8'h00,  4'b0001);
        single("slt_t",     3'd7, 8'hFE,  8'h01,  8'd1,   4'b0000);
        single("slt_f",     3'd7, 8'h01,  8'hFE,  8'd0,   4'b0001);
        single("xor",       3'd4, 8'hF0,  8'hAA,  8'h5A,  4'b0000);

        // Backpressure: five ADD(i,i) with the consumer stalled for 6 cycles
        out_ready = 1'b0;
        nxt = 1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (nxt <= 5);
            op = 3'd0;
            a  = 8'(nxt);
            b  = 8'(nxt);
            #1;
            chk("bp_ready", 32'(in_ready), 32'(bp_ir[c]));
            if (in_valid && in_ready) nxt++;
            tick();
            if (c >= 1) chk("bp_hold", 32'({out_valid, out}), 32'({1'b1, 8'd2}));
        end
        chk("bp_accepted", 32'(nxt), 32'd3);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got_q.size() < 5; c++) begin
            in_valid = (nxt <= 5);
            a = 8'(nxt);
            b = 8'(nxt);
            #1;
            if (in_valid && in_ready) nxt++;
            if (out_valid) got_q.push_back(int'(out));
            tick();
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(got_q.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            chk("bp_order", 32'((got_q.size() > k) ? got_q[k] : -1), 32'(2 * (k + 1)));
        tick();

        // Reset with two items buffered
        out_ready = 1'b0;
        put(3'd0, 8'd10, 8'd20);
        tick();
        put(3'd0, 8'd30, 8'd40);
        tick();
        in_valid = 1'b0;
        chk("mid_full", 32'({out_valid, in_ready}), 32'({1'b1, 1'b0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst", 32'({out_valid, flags, out}), 32'd0);
        chk("mid_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        single("post_rst", 3'd0, 8'd3, 8'd4, 8'd7, 4'b0000);

        // WIDTH=16 instance
        single16("w16_add", 3'd0, 16'hFFFF, 16'd1, 16'h0000, 4'b0011);
        single16("w16_sub", 3'd1, 16'h8000, 16'd1, 16'h7FFF, 4'b1000);
        single16("w16_shr", 3'd6, 16'h8001, 16'd15, 16'h0001, 4'b0000);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
